scoreboard_ctrl: RTL and testbench
==================================

Name: scoreboard_ctrl

Overview:
Issue controller between IDU and EXU in the multi-stage core.
- Tracks in-flight GPR and CSR writers in per-register counters.
- Blocks issue on RAW hazards, saturated WAW, and serializing instructions (ecall/ebreak/fence).
- Releases blocked instructions when WBU retires the producing write.
- Owns the IDU->EXU valid/ready handshake; replaces ad hoc stage-state comparisons.

Parameters:
NGPR, 32, number of GPRs (x0 never tracked)
NCSR, 4, number of tracked CSRs (index width 2)
CNT_W, 2, per-register in-flight counter width; max in-flight writers per register = 2^CNT_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dec_valid  in  1  IDU has a decoded instruction
dec_ready  out  1  instruction accepted this cycle
dec_rs1  in  5  source 1 index
dec_rs1_used  in  1  rs1 is read
dec_rs2  in  5  source 2 index
dec_rs2_used  in  1  rs2 is read
dec_rd  in  5  destination index
dec_rd_we  in  1  writes GPR
dec_csr_rs  in  2  CSR read index
dec_csr_rs_used  in  1  reads CSR
dec_csr_rd  in  2  CSR write index
dec_csr_we  in  1  writes CSR
dec_serialize  in  1  ecall/ebreak/fence; must issue with pipeline empty
flush  in  1  redirect; kill the instruction at decode
exu_ready  in  1  EXU can accept
issue_valid  out  1  valid to EXU
wb_valid  in  1  WBU retiring an instruction
wb_rd  in  5  retiring GPR index
wb_we  in  1  retiring GPR write
wb_csr_rd  in  2  retiring CSR index
wb_csr_we  in  1  retiring CSR write
pipe_empty  out  1  all counters zero
stall_cnt  out  32  cycles with dec_valid=1 and hazard=1
sb_err  out  1  sticky: retire underflow or issue overflow

Behaviour:
Decided: one clock, clk. Reset rst is synchronous and active-high.

Reset values:
- All counters 0.
- stall_cnt=0, sb_err=0.
- Therefore issue_valid=0 whenever dec_valid=0, and pipe_empty=1.

Hazard (combinational, from registered counters only):
- RAW: (rs1_used & rs1!=0 & gcnt[rs1]!=0) | (rs2_used & rs2!=0 & gcnt[rs2]!=0) | (csr_rs_used & ccnt[csr_rs]!=0).
- WAW saturation: rd_we & rd!=0 & gcnt[rd]==max, or csr_we & ccnt[csr_rd]==max.
- Serialize: dec_serialize & !pipe_empty.
- No same-cycle bypass from wb_*: a retiring write unblocks its dependents on the following cycle.

Handshake:
- issue_valid = dec_valid & !hazard & !flush.
- dec_ready = issue_valid & exu_ready.
- fire = dec_ready.
- dec_ready is never asserted without dec_valid.
- No combinational path from wb_* to dec_ready.

Counter update, each posedge:
- inc when fire & rd_we & rd!=0.
- dec when wb_valid & wb_we & wb_rd!=0.
- Same register inc and dec in the same cycle: counter unchanged.
- Different registers: both update independently.
- CSR counters follow the same rules with no x0 exemption.

Boundary conditions:
- Decrement of a zero counter: counter stays 0, sb_err set.
- Increment at max: unreachable because of the WAW stall. If it occurs anyway, saturate and set sb_err.
- stall_cnt wraps at 2^32.
- flush: suppresses issue only. In-flight counters are untouched, since those instructions still retire.
- rst mid-operation: every counter and sb_err clear in the next cycle regardless of wb_* or dec_*.
- Serializing instruction that also writes rd: counts normally once issued.
- pipe_empty is registered-state derived: OR-reduction of all counters, inverted.

Decomposition:
Shared package core_pkg holds:
- GPR_IDX_W=5, CSR_IDX_W=2.
- CSR index constants: MSTATUS, MTVEC, MEPC, MCAUSE.
- typedef sb_dec_t bundling the dec_* fields.

One sub-module, sb_counter: a CNT_W up/down saturating counter with inc, dec, zero, max and err outputs, instantiated NGPR-1 + NCSR times via generate. The top holds the hazard logic, handshake and perf counter.

Test Plan:
1. Reset, then dec_valid=1, rs1=5 used, gcnt all 0, exu_ready=1 -> issue_valid=1 and dec_ready=1 same cycle; stall_cnt stays 0.
2. Issue rd=5 we at cycle 0, then rs1=5 at cycle 1 -> dec_ready=0 until the cycle after wb_valid&wb_we&wb_rd=5; stall_cnt equals the blocked cycles (e.g. 3).
3. Same cycle: issue rd=7 and retire wb_rd=7 with gcnt[7]=1 -> gcnt[7] stays 1; a following rs2=7 reader still stalls.
4. dec_serialize=1 with gcnt[3]=2 -> stall through two retires of x3; issue on the cycle pipe_empty=1.
5. rd=0 issued and rs1=0 read -> no counter change, no stall; wb_rd=0 retire -> no sb_err.
6. wb_valid, wb_we, wb_rd=9 with gcnt[9]=0 -> sb_err=1 sticky; rst=1 for one cycle -> sb_err=0, stall_cnt=0, pipe_empty=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: register index widths, tracked CSR indices and the
// decoded-instruction bundle handed from IDU to the issue scoreboard.
package core_pkg;

  localparam int GPR_IDX_W = 5;
  localparam int CSR_IDX_W = 2;

  localparam logic [CSR_IDX_W-1:0] CSR_MSTATUS = 2'd0;
  localparam logic [CSR_IDX_W-1:0] CSR_MTVEC   = 2'd1;
  localparam logic [CSR_IDX_W-1:0] CSR_MEPC    = 2'd2;
  localparam logic [CSR_IDX_W-1:0] CSR_MCAUSE  = 2'd3;

  typedef struct packed {
    logic [GPR_IDX_W-1:0] rs1;
    logic                 rs1_used;
    logic [GPR_IDX_W-1:0] rs2;
    logic                 rs2_used;
    logic [GPR_IDX_W-1:0] rd;
    logic                 rd_we;
    logic [CSR_IDX_W-1:0] csr_rs;
    logic                 csr_rs_used;
    logic [CSR_IDX_W-1:0] csr_rd;
    logic                 csr_we;
    logic                 serialize;
  } sb_dec_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight writer counter: saturating up/down with a one-cycle
// error pulse on underflow or overflow attempts.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic max_o,
  output logic err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign zero_o = (cnt_q == '0);
  assign max_o  = (cnt_q == '1);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (max_o) err_o = 1'b1;
      else       cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (zero_o) err_o = 1'b1;
      else        cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: registers use non-blocking assignment so every flop samples the
  // pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scoreboard_ctrl.sv
// Issue scoreboard between IDU and EXU: counts in-flight GPR/CSR writers,
// blocks issue on RAW, saturated WAW and serialization, owns the handshake.
module scoreboard_ctrl
  import core_pkg::*;
#(
  parameter int NGPR  = 32,
  parameter int NCSR  = 4,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [4:0]  dec_rs1,
  input  logic        dec_rs1_used,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_rs2_used,
  input  logic [4:0]  dec_rd,
  input  logic        dec_rd_we,
  input  logic [1:0]  dec_csr_rs,
  input  logic        dec_csr_rs_used,
  input  logic [1:0]  dec_csr_rd,
  input  logic        dec_csr_we,
  input  logic        dec_serialize,
  input  logic        flush,
  input  logic        exu_ready,
  output logic        issue_valid,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_we,
  input  logic [1:0]  wb_csr_rd,
  input  logic        wb_csr_we,
  output logic        pipe_empty,
  output logic [31:0] stall_cnt,
  output logic        sb_err
);

  sb_dec_t dec;
  assign dec = '{rs1: dec_rs1, rs1_used: dec_rs1_used, rs2: dec_rs2,
                 rs2_used: dec_rs2_used, rd: dec_rd, rd_we: dec_rd_we,
                 csr_rs: dec_csr_rs, csr_rs_used: dec_csr_rs_used,
                 csr_rd: dec_csr_rd, csr_we: dec_csr_we,
                 serialize: dec_serialize};

  logic [NGPR-1:0] g_zero, g_max, g_err;
  logic [NCSR-1:0] c_zero, c_max, c_err;
  logic            fire;

  // x0 is never written, so it reads as permanently idle.
  assign g_zero[0] = 1'b1;
  assign g_max[0]  = 1'b0;
  assign g_err[0]  = 1'b0;

  for (genvar i = 1; i < NGPR; i++) begin : g_gpr
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (fire && dec.rd_we && (dec.rd == GPR_IDX_W'(i))),
      .dec_i  (wb_valid && wb_we && (wb_rd == GPR_IDX_W'(i))),
      .zero_o (g_zero[i]),
      .max_o  (g_max[i]),
      .err_o  (g_err[i])
    );
  end

  for (genvar j = 0; j < NCSR; j++) begin : g_csr
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (fire && dec.csr_we && (dec.csr_rd == CSR_IDX_W'(j))),
      .dec_i  (wb_valid && wb_csr_we && (wb_csr_rd == CSR_IDX_W'(j))),
      .zero_o (c_zero[j]),
      .max_o  (c_max[j]),
      .err_o  (c_err[j])
    );
  end

  assign pipe_empty = (&g_zero) && (&c_zero);

  // Hazards look only at registered counter state; a retire this cycle
  // unblocks its dependents next cycle.
  logic raw_haz, waw_haz, ser_haz, hazard;
  assign raw_haz = (dec.rs1_used && !g_zero[dec.rs1])
                || (dec.rs2_used && !g_zero[dec.rs2])
                || (dec.csr_rs_used && !c_zero[dec.csr_rs]);
  assign waw_haz = (dec.rd_we && g_max[dec.rd])
                || (dec.csr_we && c_max[dec.csr_rd]);
  assign ser_haz = dec.serialize && !pipe_empty;
  assign hazard  = raw_haz || waw_haz || ser_haz;

  assign issue_valid = dec_valid && !hazard && !flush;
  assign dec_ready   = issue_valid && exu_ready;
  assign fire        = dec_ready;

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        sb_err_q, sb_err_d;

  assign stall_cnt_d = (dec_valid && hazard) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  assign sb_err_d    = sb_err_q || (|g_err) || (|c_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl: stimulus queues the cycle each issue is
// expected to fire; a negedge monitor pops and compares on every dec_ready.
module tb_scoreboard_ctrl;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rs1_used, dec_rs2_used, dec_rd_we;
  logic [1:0]  dec_csr_rs, dec_csr_rd;
  logic        dec_csr_rs_used, dec_csr_we, dec_serialize;
  logic        flush, exu_ready, issue_valid;
  logic        wb_valid, wb_we, wb_csr_we;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_csr_rd;
  logic        pipe_empty, sb_err;
  logic [31:0] stall_cnt;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          exp_q[$];

  scoreboard_ctrl dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs1_used(dec_rs1_used),
    .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
    .dec_csr_rs(dec_csr_rs), .dec_csr_rs_used(dec_csr_rs_used),
    .dec_csr_rd(dec_csr_rd), .dec_csr_we(dec_csr_we),
    .dec_serialize(dec_serialize), .flush(flush), .exu_ready(exu_ready),
    .issue_valid(issue_valid),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_csr_rd(wb_csr_rd), .wb_csr_we(wb_csr_we),
    .pipe_empty(pipe_empty), .stall_cnt(stall_cnt), .sb_err(sb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted instruction must match the next queued fire cycle.
  always @(negedge clk) begin
    if (dec_ready === 1'b1) begin
      check("ready_implies_valid", {31'd0, dec_valid}, 32'd1);
      if (exp_q.size() == 0) check("unexpected_fire", 32'd1, 32'd0);
      else check("fire_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs1_used = 0; dec_rs2 = 0; dec_rs2_used = 0;
    dec_rd = 0; dec_rd_we = 0; dec_csr_rs = 0; dec_csr_rs_used = 0;
    dec_csr_rd = 0; dec_csr_we = 0; dec_serialize = 0; flush = 0;
    wb_valid = 0; wb_rd = 0; wb_we = 0; wb_csr_rd = 0; wb_csr_we = 0;
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    idle();
    dec_valid = 1; dec_rd = rd; dec_rd_we = 1;
    exp_q.push_back(cyc);
    tick();
  endtask

  task automatic retire(input logic [4:0] rd);
    wb_valid = 1; wb_we = 1; wb_rd = rd;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); exu_ready = 1; rst = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    check("rst_pipe_empty", {31'd0, pipe_empty}, 32'd1);
    check("rst_sb_err", {31'd0, sb_err}, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    tick();

    // 1: independent reader issues immediately
    dec_valid = 1; dec_rs1 = 5; dec_rs1_used = 1;
    exp_q.push_back(cyc);
    @(negedge clk);
    check("t1_issue_valid", {31'd0, issue_valid}, 32'd1);
    check("t1_dec_ready", {31'd0, dec_ready}, 32'd1);
    check("t1_stall_cnt", stall_cnt, 32'd0);
    tick(); idle();

    // 2: RAW on x5, blocked three cycles, no same-cycle bypass
    issue_rd(5);
    idle(); dec_valid = 1; dec_rs1 = 5; dec_rs1_used = 1;
    exp_q.push_back(cyc + 3);
    @(negedge clk);
    check("t2_raw_block", {31'd0, dec_ready}, 32'd0);
    tick(); tick();
    retire(5);
    @(negedge clk);
    check("t2_no_bypass", {31'd0, dec_ready}, 32'd0);
    tick();
    wb_valid = 0; wb_we = 0;
    @(negedge clk);
    check("t2_stall_cnt", stall_cnt, 32'd3);
    tick(); idle();

    // 3: same-register issue+retire keeps count at 1
    issue_rd(7);
    dec_valid = 1; dec_rd = 7; dec_rd_we = 1; retire(7);
    exp_q.push_back(cyc);
    tick();
    idle(); dec_valid = 1; dec_rs2 = 7; dec_rs2_used = 1;
    @(negedge clk);
    check("t3_still_busy", {31'd0, issue_valid}, 32'd0);
    retire(7);
    exp_q.push_back(cyc + 1);
    tick(); wb_valid = 0; wb_we = 0;
    tick(); idle();

    // 4: serialize waits for two x3 retires, then counts its own rd
    issue_rd(3);
    issue_rd(3);
    idle(); dec_valid = 1; dec_serialize = 1; dec_rd = 4; dec_rd_we = 1;
    retire(3);
    exp_q.push_back(cyc + 2);
    @(negedge clk);
    check("t4_not_empty", {31'd0, pipe_empty}, 32'd0);
    check("t4_ser_block", {31'd0, dec_ready}, 32'd0);
    tick(); tick();
    wb_valid = 0; wb_we = 0;
    @(negedge clk);
    check("t4_empty_at_issue", {31'd0, pipe_empty}, 32'd1);
    check("t4_stall_cnt", stall_cnt, 32'd6);
    tick(); idle();
    @(negedge clk);
    check("t4_ser_rd_counted", {31'd0, pipe_empty}, 32'd0);
    retire(4);
    tick(); idle();

    // WAW saturation on x10 at three in-flight writers
    issue_rd(10); issue_rd(10); issue_rd(10);
    idle(); dec_valid = 1; dec_rd = 10; dec_rd_we = 1;
    @(negedge clk);
    check("waw_saturated", {31'd0, issue_valid}, 32'd0);
    retire(10);
    exp_q.push_back(cyc + 1);
    tick(); wb_valid = 0; wb_we = 0;
    tick(); idle();
    retire(10);
    tick(); tick(); tick(); idle();
    @(negedge clk);
    check("waw_drained", {31'd0, pipe_empty}, 32'd1);
    check("waw_stall_cnt", stall_cnt, 32'd7);

    // CSR RAW on MEPC
    tick();
    dec_valid = 1; dec_csr_rd = CSR_MEPC; dec_csr_we = 1;
    exp_q.push_back(cyc);
    tick(); idle();
    dec_valid = 1; dec_csr_rs = CSR_MEPC; dec_csr_rs_used = 1;
    @(negedge clk);
    check("csr_raw_block", {31'd0, issue_valid}, 32'd0);
    wb_valid = 1; wb_csr_we = 1; wb_csr_rd = CSR_MEPC;
    exp_q.push_back(cyc + 1);
    tick(); wb_valid = 0; wb_csr_we = 0;
    tick(); idle();

    // flush kills decode but leaves in-flight counts alone
    issue_rd(12);
    idle(); dec_valid = 1; flush = 1; dec_rs1 = 1; dec_rs1_used = 1;
    @(negedge clk);
    check("flush_kill", {31'd0, issue_valid}, 32'd0);
    tick(); idle();
    @(negedge clk);
    check("flush_keeps_count", {31'd0, pipe_empty}, 32'd0);
    check("flush_no_stall", stall_cnt, 32'd8);
    retire(12);
    tick(); idle();

    // 5: x0 is never tracked
    dec_valid = 1; dec_rd = 0; dec_rd_we = 1; dec_rs1 = 0; dec_rs1_used = 1;
    retire(0);
    exp_q.push_back(cyc);
    tick(); idle();
    @(negedge clk);
    check("t5_x0_empty", {31'd0, pipe_empty}, 32'd1);
    check("t5_x0_no_err", {31'd0, sb_err}, 32'd0);

    // 6: underflow sets sticky error; reset clears everything
    tick();
    issue_rd(12);
    idle(); retire(9);
    tick(); idle();
    @(negedge clk);
    check("t6_underflow_err", {31'd0, sb_err}, 32'd1);
    tick();
    @(negedge clk);
    check("t6_err_sticky", {31'd0, sb_err}, 32'd1);
    check("t6_busy_before_rst", {31'd0, pipe_empty}, 32'd0);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("t6_rst_err", {31'd0, sb_err}, 32'd0);
    check("t6_rst_stall", stall_cnt, 32'd0);
    check("t6_rst_empty", {31'd0, pipe_empty}, 32'd1);

    tick(); tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
